// File: rtl/cache_arb_pkg.sv
// Shared types and width constants for the cache/memory arbiter.
// Holds the arbiter states, requester IDs and transaction opcodes.
package cache_arb_pkg;

    localparam int unsigned LINE_W = 256;
    localparam int unsigned ADDR_W = 32;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RELEASE
    } arb_state_t;

    typedef enum logic {
        REQ_I,
        REQ_D
    } arb_req_t;

    typedef enum logic {
        OP_READ,
        OP_WRITE
    } arb_op_t;

    function automatic arb_req_t other_req(input arb_req_t r);
        return (r == REQ_I) ? REQ_D : REQ_I;
    endfunction

endpackage

// File: rtl/cache_arb_pick.sv
// Combinational grant selection between the icache and dcache requesters.
// Fixed priority favours dcache; round-robin favours the one not granted last.
module cache_arb_pick
    import cache_arb_pkg::*;
#(
    parameter bit RR_MODE = 1'b0
) (
    input  logic     i_req,
    input  logic     d_req,
    input  arb_req_t last_grant,
    output logic     grant_valid,
    output arb_req_t grant_id
);

    always_comb begin
        grant_valid = i_req | d_req;
        grant_id    = REQ_I;
        if (i_req && d_req) begin
            grant_id = RR_MODE ? other_req(last_grant) : REQ_D;
        end else if (d_req) begin
            grant_id = REQ_D;
        end
    end

endmodule

// File: rtl/cache_mem_arbiter.sv
// Shares one line-granular memory port between the L1 icache and dcache,
// one transaction at a time, with a release cycle after every response.
module cache_mem_arbiter #(
    parameter int unsigned RR_MODE = 0,
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned LINE_W  = 256
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              icache_read,
    input  logic [ADDR_W-1:0] icache_address,
    output logic              icache_resp,
    output logic [LINE_W-1:0] icache_rdata,

    input  logic              dcache_read,
    input  logic              dcache_write,
    input  logic [ADDR_W-1:0] dcache_address,
    input  logic [LINE_W-1:0] dcache_wdata,
    output logic              dcache_resp,
    output logic [LINE_W-1:0] dcache_rdata,

    output logic              pmem_read,
    output logic              pmem_write,
    output logic [ADDR_W-1:0] pmem_address,
    output logic [LINE_W-1:0] pmem_wdata,
    input  logic              pmem_resp,
    input  logic [LINE_W-1:0] pmem_rdata
);
    import cache_arb_pkg::*;

    arb_state_t        state_q, state_d;
    arb_req_t          owner_q, owner_d;
    arb_req_t          last_grant_q, last_grant_d;
    arb_op_t           op_q, op_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LINE_W-1:0] wdata_q, wdata_d;
    logic              pmem_read_q, pmem_read_d;
    logic              pmem_write_q, pmem_write_d;

    logic              d_req;
    logic              grant_valid;
    arb_req_t          grant_id;

    assign d_req = dcache_read | dcache_write;

    cache_arb_pick #(
        .RR_MODE(RR_MODE != 0)
    ) u_pick (
        .i_req      (icache_read),
        .d_req      (d_req),
        .last_grant (last_grant_q),
        .grant_valid(grant_valid),
        .grant_id   (grant_id)
    );

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        op_d         = op_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        pmem_read_d  = pmem_read_q;
        pmem_write_d = pmem_write_q;
        icache_resp  = 1'b0;
        dcache_resp  = 1'b0;
        icache_rdata = '0;
        dcache_rdata = '0;

        unique case (state_q)
            IDLE: begin
                if (grant_valid) begin
                    owner_d      = grant_id;
                    last_grant_d = grant_id;
                    if (grant_id == REQ_D) begin
                        addr_d  = dcache_address;
                        wdata_d = dcache_wdata;
                        // A simultaneous read+write from dcache is treated as a writeback.
                        op_d    = dcache_write ? OP_WRITE : OP_READ;
                    end else begin
                        addr_d  = icache_address;
                        wdata_d = '0;
                        op_d    = OP_READ;
                    end
                    pmem_read_d  = (op_d == OP_READ);
                    pmem_write_d = (op_d == OP_WRITE);
                    state_d      = BUSY;
                end
            end
            BUSY: begin
                // A response coinciding with reset is dropped, not forwarded.
                if (pmem_resp && !rst) begin
                    if (owner_q == REQ_I) begin
                        icache_resp  = 1'b1;
                        icache_rdata = pmem_rdata;
                    end else begin
                        dcache_resp  = 1'b1;
                        dcache_rdata = pmem_rdata;
                    end
                    pmem_read_d  = 1'b0;
                    pmem_write_d = 1'b0;
                    state_d      = RELEASE;
                end
            end
            RELEASE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            owner_q      <= REQ_I;
            last_grant_q <= REQ_I;
            op_q         <= OP_READ;
            addr_q       <= '0;
            wdata_q      <= '0;
            pmem_read_q  <= 1'b0;
            pmem_write_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            op_q         <= op_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            pmem_read_q  <= pmem_read_d;
            pmem_write_q <= pmem_write_d;
        end
    end

    assign pmem_read    = pmem_read_q;
    assign pmem_write   = pmem_write_q;
    assign pmem_address = addr_q;
    assign pmem_wdata   = wdata_q;

endmodule

// File: doc/cache_mem_arbiter.md
Name: cache_mem_arbiter

Overview:
- Two-port arbiter that shares the single 256-bit line-granular physical memory port between the L1 instruction cache (read-only) and the L1 data cache (read/write).
- Sits between the two cache miss controllers and physical memory.
- Serialises one line transaction at a time and latches the winner's command.
- Inserts the one-cycle release gap the memory needs after every response, so the memory never sees a stale request and restarts.

Parameters:
- RR_MODE, 0: 0 = fixed priority (dcache always wins ties); 1 = round-robin (tie goes to the requester not granted last).
- ADDR_W, 32: address width.
- LINE_W, 256: line data width.

Ports:
- clk  in  1  clock; all state changes on posedge.
- rst  in  1  synchronous active-high reset.
- icache_read  in  1  icache line read request; held until icache_resp.
- icache_address  in  ADDR_W  icache line address.
- icache_resp  out  1  one-cycle completion pulse to icache.
- icache_rdata  out  LINE_W  line data to icache; valid while icache_resp=1.
- dcache_read  in  1  dcache line read request.
- dcache_write  in  1  dcache line writeback request.
- dcache_address  in  ADDR_W  dcache line address.
- dcache_wdata  in  LINE_W  writeback line.
- dcache_resp  out  1  one-cycle completion pulse to dcache.
- dcache_rdata  out  LINE_W  line data to dcache; valid while dcache_resp=1.
- pmem_read  out  1  memory read strobe (registered).
- pmem_write  out  1  memory write strobe (registered).
- pmem_address  out  ADDR_W  latched address.
- pmem_wdata  out  LINE_W  latched write data.
- pmem_resp  in  1  memory completion pulse.
- pmem_rdata  in  LINE_W  memory line data.

Behaviour:
- States: IDLE, BUSY, RELEASE. Registers: owner (I/D), op (read/write), addr_q, wdata_q, last_grant.
- Reset values: state=IDLE, owner=I, op=read, addr_q=0, wdata_q=0, last_grant=I. All outputs are 0: pmem_read, pmem_write, pmem_address, pmem_wdata, icache_resp, dcache_resp, icache_rdata, dcache_rdata.
- IDLE:
  - No request: stay in IDLE.
  - Only icache_read: grant I, op=read.
  - Only dcache_read|dcache_write: grant D.
  - Both requesting, RR_MODE=0: grant D.
  - Both requesting, RR_MODE=1: grant the requester other than last_grant.
  - On grant: latch address/wdata/op, update last_grant, go to BUSY.
  - dcache_read and dcache_write both high: op=write.
- BUSY:
  - pmem_read=(op==read), pmem_write=(op==write); pmem_address=addr_q, pmem_wdata=wdata_q.
  - All requester inputs are ignored.
  - When pmem_resp=1: drive owner's resp=1 combinationally in the same cycle. Owner's rdata passes pmem_rdata through; the non-owner's rdata is 0. Then go to RELEASE.
- RELEASE: pmem_read=pmem_write=0 for exactly one cycle, then go to IDLE. pmem_resp here is ignored.
- Latency: request seen in IDLE at edge N; pmem strobe visible from cycle N+1. Requester resp arrives in the same cycle as pmem_resp. Minimum gap between two memory transactions is 2 cycles (RELEASE, IDLE).
- A requester dropping its request during BUSY does not abort the transaction. It completes with the latched command and the resp pulse is still issued.
- At most one resp output is high in any cycle; never both.
- pmem_resp in IDLE or RELEASE is never forwarded.
- rst during BUSY: next cycle state=IDLE, strobes 0. Any in-flight memory response is dropped; no resp is forwarded.
- A requester still asserting in the RELEASE cycle is not regranted until IDLE evaluates it. Requesters must drop their request the cycle after their resp.

Decomposition:
- Package cache_arb_pkg:
  - enum arb_state_t {IDLE, BUSY, RELEASE}.
  - enum arb_req_t {REQ_I, REQ_D}.
  - enum arb_op_t {OP_READ, OP_WRITE}.
  - Width constants LINE_W=256, ADDR_W=32.
- One sub-module, cache_arb_pick:
  - Purely combinational grant select.
  - Inputs: i_req, d_req, last_grant, RR_MODE.
  - Outputs: grant_valid, grant_id.
- The FSM and latches stay in the top module.

Test Plan:
- icache_read, address 0x0000_0040, alone; memory returns 0xAA..AA -> pmem_read=1 with pmem_address=0x40 from the next cycle; icache_resp single pulse with rdata 0xAA..AA; dcache_resp stays 0; RELEASE cycle shows pmem_read=0.
- dcache_write, address 0x0000_0100, wdata 0x1234..; then dcache_read of 0x100 -> pmem_write with matching data; after a 2-cycle gap pmem_read; dcache_rdata equals 0x1234...
- icache and dcache requesting in the same IDLE cycle, RR_MODE=0 -> D served first, then I. Repeat with both held continuously: D always wins whenever both request.
- RR_MODE=1, both held continuously for 4 transactions -> grants alternate D, I, D, I (last_grant resets to I).
- rst asserted in the 3rd BUSY cycle of an icache read -> strobes 0 the next cycle; a late pmem_resp pulse produces no icache_resp/dcache_resp; a new request afterwards is served normally.
- Forced pmem_resp=1 during IDLE and RELEASE -> no resp forwarded; state unchanged.
